// File: rtl/fir_pkg.sv
// Shared types and helpers for the multi-channel FIR filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

    // Sequencer states: wait for a sample set, walk the taps, emit the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_t;

    // Largest value representable in a signed field of width w.
    function automatic longint sat_hi(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed field of width w.
    function automatic longint sat_lo(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/fir_filt_mc_if.sv
// Sample-stream bundle between the ADC capture side and the filter.
// Latency: n/a (wires only).
// Backpressure: none; producer watches busy, drops are flagged on overrun.
interface fir_filt_mc_if #(
    parameter int CHANNELS  = 2,
    parameter int SIG_WIDTH = 12
);
    logic                          in_valid;
    logic [CHANNELS*SIG_WIDTH-1:0] in_data;
    logic                          busy;
    logic                          overrun;
    logic                          out_valid;
    logic [CHANNELS*SIG_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data,
        input  busy, overrun, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data,
        output busy, overrun, out_valid, out_data
    );
endinterface

// File: rtl/fir_mac_lane.sv
// One channel's accumulator plus round / arithmetic-shift / saturate stage.
// Latency: one cycle per accumulated tap; result registered one cycle after out_en.
// Backpressure: none; sequencing is entirely driven by the parent's control strobes.
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int SIG_WIDTH   = 12,
    parameter int COEF_WIDTH  = 18,
    parameter int ACC_WIDTH   = 40,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          acc_clr,
    input  logic                          acc_en,
    input  logic                          out_en,
    input  logic signed [SIG_WIDTH-1:0]   smp,
    input  logic signed [COEF_WIDTH-1:0]  coef,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic signed [SIG_WIDTH-1:0]   res
);

    localparam int PW = SIG_WIDTH + COEF_WIDTH;
    // One extra bit so the rounding increment can never wrap the accumulator.
    localparam int RW = ACC_WIDTH + 1;
    localparam logic signed [RW-1:0] SAT_HI = RW'(sat_hi(SIG_WIDTH));
    localparam logic signed [RW-1:0] SAT_LO = RW'(sat_lo(SIG_WIDTH));

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [PW-1:0]        prod;
    logic signed [RW-1:0]        rnd;
    logic signed [RW-1:0]        sum;
    logic signed [RW-1:0]        shifted;
    logic signed [SIG_WIDTH-1:0] sat;

    // Full-precision product and the rounded, shifted, clamped result.
    always_comb begin
        prod = PW'(smp) * PW'(coef);
        rnd  = '0;
        if (shift != '0) begin
            rnd = RW'(1) << (shift - SHIFT_WIDTH'(1));
        end
        sum     = RW'(acc_q) + rnd;
        shifted = sum >>> shift;
        if (shifted > SAT_HI) begin
            sat = SIG_WIDTH'(SAT_HI);
        end else if (shifted < SAT_LO) begin
            sat = SIG_WIDTH'(SAT_LO);
        end else begin
            sat = SIG_WIDTH'(shifted);
        end
    end

    // Accumulate one tap per enabled cycle; capture the result on out_en.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            acc_q <= '0;
            res   <= '0;
        end else begin
            if (acc_clr) begin
                acc_q <= '0;
            end else if (acc_en) begin
                acc_q <= acc_q + ACC_WIDTH'(prod);
            end
            if (out_en) begin
                res <= sat;
            end
        end
    end

endmodule

// File: rtl/fir_filt_mc.sv
// Multi-channel time-multiplexed signed FIR, one MAC per channel, one tap per clock.
// Latency: in_valid in cycle t gives out_valid in cycle t+COEF_COUNT+2.
// Backpressure: none; sample sets arriving while busy (or in the output cycle) are dropped and flagged on overrun.
module fir_filt_mc
    import fir_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int SIG_WIDTH  = 12,
    parameter int COEF_WIDTH = 18,
    parameter int COEF_COUNT = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int MAX_SHIFT  = 32,
    localparam int TW  = $clog2(COEF_COUNT),
    localparam int SHW = $clog2(MAX_SHIFT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    fir_filt_mc_if.slave          bus,
    input  logic                  coef_we,
    input  logic [TW-1:0]         coef_addr,
    input  logic [COEF_WIDTH-1:0] coef_wdata,
    output logic                  coef_ack,
    output logic [COEF_WIDTH-1:0] coef_rdata,
    input  logic                  shift_we,
    input  logic [SHW-1:0]        shift_in,
    output logic [SHW-1:0]        shift
);

    fir_state_t state_q, state_d;

    logic [TW-1:0] tap_q;
    logic [TW-1:0] wr_ptr_q;
    logic [TW-1:0] rd_idx;

    logic signed [SIG_WIDTH-1:0]  dline_q [CHANNELS][COEF_COUNT];
    logic signed [COEF_WIDTH-1:0] coef_q  [COEF_COUNT];
    logic        [SHW-1:0]        shift_q;

    logic accept;
    logic drop;
    logic coef_acc;
    logic tap_last;
    logic acc_clr;
    logic acc_en;
    logic out_en;

    logic                  overrun_q;
    logic                  out_valid_q;
    logic                  coef_ack_q;
    logic [COEF_WIDTH-1:0] coef_rdata_q;

    logic signed [SIG_WIDTH-1:0]   lane_res [CHANNELS];
    logic [CHANNELS*SIG_WIDTH-1:0] out_data_w;

    // Input qualification: flush wins over a new sample set, and the
    // coefficient port is only open while the datapath is quiescent.
    always_comb begin
        accept   = bus.in_valid && !flush && (state_q == ST_IDLE);
        drop     = bus.in_valid && !flush && (state_q != ST_IDLE);
        coef_acc = coef_we && (state_q == ST_IDLE) && !accept;
        tap_last = (tap_q == TW'(COEF_COUNT - 1));
        // Newest sample sits just behind the write pointer; older taps further back.
        rd_idx   = wr_ptr_q - TW'(1) - tap_q;
    end

    // Next-state and lane control strobes.
    always_comb begin
        state_d = state_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        out_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_clr = 1'b1;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_en = 1'b1;
                if (tap_last) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                out_en  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort anything in flight without producing a result.
        if (flush) begin
            state_d = ST_IDLE;
            acc_en  = 1'b0;
            out_en  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tap counter restarts with every accepted sample set.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            tap_q <= '0;
        end else if (acc_clr) begin
            tap_q <= '0;
        end else if (acc_en) begin
            tap_q <= tap_q + TW'(1);
        end
    end

    // Circular delay line, one row per channel, shared write pointer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < COEF_COUNT; k++) begin
                    dline_q[c][k] <= '0;
                end
            end
        end else if (accept) begin
            wr_ptr_q <= wr_ptr_q + TW'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                dline_q[c][wr_ptr_q] <= bus.in_data[c*SIG_WIDTH +: SIG_WIDTH];
            end
        end
    end

    // Coefficient store; defaults to a unit impulse so the filter passes through.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < COEF_COUNT; k++) begin
                coef_q[k] <= '0;
            end
            coef_q[0] <= COEF_WIDTH'(1);
        end else if (coef_acc) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

    // Registered coefficient readback and write acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_ack_q   <= 1'b0;
            coef_rdata_q <= '0;
        end else begin
            coef_ack_q   <= coef_acc;
            coef_rdata_q <= coef_q[coef_addr];
        end
    end

    // Result shift; sampled by the lanes only in the output cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else if (shift_we) begin
            shift_q <= shift_in;
        end
    end

    // Sticky drop flag and the output strobe.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_en;
            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        fir_mac_lane #(
            .SIG_WIDTH   (SIG_WIDTH),
            .COEF_WIDTH  (COEF_WIDTH),
            .ACC_WIDTH   (ACC_WIDTH),
            .SHIFT_WIDTH (SHW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .acc_clr (acc_clr),
            .acc_en  (acc_en),
            .out_en  (out_en),
            .smp     (dline_q[c][rd_idx]),
            .coef    (coef_q[tap_q]),
            .shift   (shift_q),
            .res     (lane_res[c])
        );
    end

    // Pack per-lane results onto the output bus.
    always_comb begin
        out_data_w = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            out_data_w[c*SIG_WIDTH +: SIG_WIDTH] = lane_res[c];
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.overrun   = overrun_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_w;
    assign coef_ack      = coef_ack_q;
    assign coef_rdata    = coef_rdata_q;
    assign shift         = shift_q;

endmodule

// File: tb/tb_fir_filt_mc.sv
// Directed bench for fir_filt_mc with a reference-model scoreboard.
// Latency: checks out_valid arrives 18 cycles after the driving cycle.
// Backpressure: exercises drops while busy / in the output cycle and flush aborts.
module tb_fir_filt_mc;

    localparam int CH = 2;
    localparam int SW = 12;
    localparam int CW = 18;
    localparam int NT = 16;
    localparam int AW = 40;
    localparam int MS = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          coef_we;
    logic [3:0]    coef_addr;
    logic [CW-1:0] coef_wdata;
    logic          coef_ack;
    logic [CW-1:0] coef_rdata;
    logic          shift_we;
    logic [4:0]    shift_in;
    logic [4:0]    shift;

    fir_filt_mc_if #(.CHANNELS(CH), .SIG_WIDTH(SW)) bus ();

    fir_filt_mc #(
        .CHANNELS   (CH),
        .SIG_WIDTH  (SW),
        .COEF_WIDTH (CW),
        .COEF_COUNT (NT),
        .ACC_WIDTH  (AW),
        .MAX_SHIFT  (MS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_ack   (coef_ack),
        .coef_rdata (coef_rdata),
        .shift_we   (shift_we),
        .shift_in   (shift_in),
        .shift      (shift)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [CH*SW-1:0] exp_q [$];
    int               t_q   [$];

    longint m_coef [NT];
    longint m_hist [CH][NT];
    int     m_shift;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one clock, sample just after the edge, score any output.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.out_valid === 1'b1) begin
            chk("out_valid_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                logic [CH*SW-1:0] e;
                int t;
                e = exp_q.pop_front();
                t = t_q.pop_front();
                chk("out_data", 64'(bus.out_data), 64'(e));
                chk("latency", 64'(cyc - t), 64'd18);
            end
        end
    endtask

    function automatic logic [CH*SW-1:0] model_eval();
        logic [CH*SW-1:0] r;
        longint acc;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            acc = 0;
            for (int k = 0; k < NT; k++) acc += m_hist[c][k] * m_coef[k];
            if (m_shift > 0) acc += longint'(1) << (m_shift - 1);
            acc = acc >>> m_shift;
            if (acc > 2047) acc = 2047;
            else if (acc < -2048) acc = -2048;
            r[c*SW +: SW] = acc[SW-1:0];
        end
        return r;
    endfunction

    task automatic model_push(input int s0, input int s1);
        for (int c = 0; c < CH; c++)
            for (int k = NT - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[0][0] = s0;
        m_hist[1][0] = s1;
        exp_q.push_back(model_eval());
        t_q.push_back(cyc);
    endtask

    task automatic send(input int s0, input int s1);
        bus.in_valid = 1'b1;
        bus.in_data  = {SW'(s1), SW'(s0)};
        model_push(s0, s1);
        tick();
        bus.in_valid = 1'b0;
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
    endtask

    // Inject a sample set the DUT must drop; model history is untouched.
    task automatic send_drop(input int s0, input int s1);
        bus.in_valid = 1'b1;
        bus.in_data  = {SW'(s1), SW'(s0)};
        tick();
        bus.in_valid = 1'b0;
        chk("overrun_set", 64'(bus.overrun), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic write_coef(input int a, input int v);
        logic [CW-1:0] vv;
        vv         = CW'(v);
        coef_addr  = 4'(a);
        coef_wdata = vv;
        coef_we    = 1'b1;
        tick();
        coef_we = 1'b0;
        chk("coef_ack", 64'(coef_ack), 64'd1);
        m_coef[a] = v;
        tick();
        chk("coef_ack_pulse", 64'(coef_ack), 64'd0);
        chk("coef_rdata", 64'(coef_rdata), 64'(vv));
    endtask

    task automatic set_shift(input int s);
        shift_in = 5'(s);
        shift_we = 1'b1;
        tick();
        shift_we = 1'b0;
        chk("shift", 64'(shift), 64'(s));
        m_shift = s;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < NT; k++) m_hist[c][k] = 0;
        exp_q.delete();
        t_q.delete();
        chk("busy_after_flush", 64'(bus.busy), 64'd0);
        chk("overrun_after_flush", 64'(bus.overrun), 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        coef_we      = 1'b0;
        coef_addr    = '0;
        coef_wdata   = '0;
        shift_we     = 1'b0;
        shift_in     = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int k = 0; k < NT; k++) m_coef[k] = 0;
        m_coef[0] = 1;
        m_shift   = 0;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < NT; k++) m_hist[c][k] = 0;

        // Reset state.
        tick();
        tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_overrun", 64'(bus.overrun), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_coef_ack", 64'(coef_ack), 64'd0);
        chk("rst_coef_rdata", 64'(coef_rdata), 64'd0);
        chk("rst_shift", 64'(shift), 64'd0);
        rst = 1'b0;
        tick();
        chk("default_coef0", 64'(coef_rdata), 64'd1);

        // Pass-through with default coefficients.
        send(100, -100);
        drain();

        // Four-tap moving sum, shift 2.
        do_flush();
        write_coef(1, 1);
        write_coef(2, 1);
        write_coef(3, 1);
        set_shift(2);
        for (int i = 0; i < 4; i++) begin
            send(400, -400);
            drain();
        end

        // Saturation at both rails.
        write_coef(0, 131071);
        write_coef(1, 0);
        write_coef(2, 0);
        write_coef(3, 0);
        set_shift(0);
        do_flush();
        send(2047, -2048);
        drain();
        send(-2048, 2047);
        drain();

        // Round half up with shift 1.
        write_coef(0, 1);
        set_shift(1);
        send(3, -3);
        drain();
        send(-4, 4);
        drain();

        // Drop while in MAC: delay line must be untouched (tap 1 exposes it).
        write_coef(1, 1);
        do_flush();
        send(10, 20);
        repeat (4) tick();
        send_drop(999, 999);
        drain();
        send(30, 40);
        drain();
        chk("overrun_sticky", 64'(bus.overrun), 64'd1);

        // Drop in the output cycle.
        do_flush();
        send(6, 8);
        repeat (16) tick();
        send_drop(500, 500);
        drain();
        send(2, 2);
        drain();

        // Flush mid-MAC aborts with no output.
        send(50, 50);
        repeat (5) tick();
        do_flush();
        repeat (25) tick();
        send(7, -7);
        drain();

        // Coefficient write while busy is ignored.
        send(1, 1);
        tick();
        coef_addr  = 4'd5;
        coef_wdata = 18'd777;
        coef_we    = 1'b1;
        tick();
        coef_we = 1'b0;
        chk("coef_ack_busy", 64'(coef_ack), 64'd0);
        drain();
        coef_addr = 4'd5;
        tick();
        tick();
        chk("coef_unchanged", 64'(coef_rdata), 64'(m_coef[5]));
        write_coef(5, 777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_filt_mc.md
Name: fir_filt_mc

Overview:
Multi-channel, signed, time-multiplexed FIR filter. It is the parametrised successor of the two-channel ADC front-end filter.
- One MAC per channel iterates over the taps, one tap per clock.
- Output is rounded, arithmetically shifted and saturated, with valid/busy handshakes and overrun detection.
- Sits between the ADC capture logic and the IQ demodulator; coefficients and shift are written by the control interface.

Parameters:
channels, 2, number of independent input channels sharing coefficients
sig_width, 12, signed sample/output width
coef_width, 18, signed coefficient width
coef_count, 16, tap count (power of two, >=2)
acc_width, 40, signed accumulator width (>= sig_width+coef_width+clog2(coef_count))
max_shift, 32, number of selectable result shift values (0..max_shift-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
flush  in  1  clears datapath state; keeps coefficients and shift
in_valid  in  1  single-cycle strobe: new sample set on in_data
in_data  in  channels*sig_width  packed signed samples; channel c at [c*sig_width +: sig_width]
busy  out  1  computation in progress
overrun  out  1  sticky: a sample set was dropped
out_valid  out  1  single-cycle strobe: out_data valid
out_data  out  channels*sig_width  packed signed filtered results
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(coef_count)  coefficient index (write and read)
coef_wdata  in  coef_width  coefficient value
coef_ack  out  1  one-cycle pulse: write accepted
coef_rdata  out  coef_width  coeffs[coef_addr], registered, 1-cycle latency
shift_we  in  1  shift write strobe
shift_in  in  clog2(max_shift)  result right-shift amount
shift  out  clog2(max_shift)  current shift

Behaviour:
- Single clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - coeffs[0]=1, all other coeffs 0 (pass-through); shift=0.
  - Delay line and accumulators 0; state IDLE.
  - busy, overrun, out_valid, coef_ack all 0; out_data=0; coef_rdata=0.
- Delay line: circular buffer of coef_count entries per channel with a shared wr_ptr. Tap k reads entry (wr_ptr-1-k) mod coef_count; the pointer wraps naturally.
- FSM:
  - IDLE: on in_valid, write in_data at wr_ptr, increment wr_ptr, clear accumulators, go MAC. busy=1 from the next cycle.
  - MAC: tap counter 0..coef_count-1; each cycle acc_c += sample_c[tap]*coeffs[tap], signed, full-precision product sign-extended to acc_width. After the last tap, go OUT.
  - OUT: per channel, if shift>0 add 2^(shift-1) (round half up), arithmetic right shift by shift, saturate to [-2^(sig_width-1), 2^(sig_width-1)-1]. Register out_data, pulse out_valid, return to IDLE, busy=0.
- Latency: in_valid at cycle t gives out_valid at t+coef_count+2. Minimum sample spacing is coef_count+2 cycles.
- in_valid while busy: sample set dropped, delay line untouched, overrun<=1. overrun is cleared only by rst or flush.
- in_valid in the same cycle the FSM returns to IDLE (OUT cycle): dropped, overrun set.
- Coefficient writes:
  - Accepted only when busy=0 and not in the in_valid-accept cycle; coef_ack pulses the following cycle.
  - A write while busy is ignored with no ack; the master retries.
- shift_we: accepted any time. The new value takes effect at the next OUT stage.
- flush:
  - Clears delay line, wr_ptr, accumulators, out_data and overrun; FSM goes to IDLE.
  - An in-progress computation is aborted with no out_valid.
  - flush has priority over in_valid in the same cycle.
- rst mid-operation: same abort, plus coefficient/shift defaults.

Decomposition:
- Shared package fir_pkg: FSM state encoding (IDLE, MAC, OUT) and helper function for saturation bounds from sig_width.
- One sub-module: fir_mac_lane (one channel's accumulator, round/shift/saturate), instantiated channels times by generate.

Test Plan:
- Reset, then in_valid with ch0=100, ch1=-100 → out_valid at t+18 (coef_count=16), out_data ch0=100, ch1=-100.
- Taps 0..3 = 1, shift=2, constant 400 input on 4 consecutive sample sets → ch0 outputs 100, 200, 300, 400.
- coeffs[0]=2^17-1 (max positive), input 2047, shift=0 → 2047 (saturated high); input -2048 → -2048 (saturated low).
- coeffs[0]=1, shift=1: input 3 → 2; input -3 → -1; input -4 → -2 (round half up).
- in_valid repeated 5 cycles after an accepted one → overrun=1, only one out_valid, delay line unchanged; flush → overrun=0.
- flush 5 cycles into MAC → no out_valid. Coef write during busy → no coef_ack, coefficient unchanged. Coef write when idle → coef_ack next cycle, coef_rdata shows the new value.
